exception_unit: RTL and testbench

EXCEPTION_UNIT -- requirements
Module: exception_unit

---
 rtl/exc_pkg.sv | 23 ++
 rtl/exception_unit_if.sv | 28 ++
 rtl/exc_byte_select.sv | 19 +
 rtl/exception_unit.sv | 86 ++++++++
 tb/tb_exception_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared cause encodings, FSM state codes and vector table default for the exception unit.
package exc_pkg;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_INV  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_DIV  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [31:0] VEC_BASE_DEF = 32'd252;

    // Fixed priority: invalid opcode beats overflow beats divide-by-zero.
    function automatic logic [1:0] pick_cause(input logic inv, input logic ovf, input logic dz);
        if (inv)      return CAUSE_INV;
        else if (ovf) return CAUSE_OVF;
        else if (dz)  return CAUSE_DIV;
        else          return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Bundle between the control path / memory port and the exception unit.
interface exception_unit_if;

    logic        check_en;
    logic        invalid_opcode_in;
    logic        overflow_in;
    logic        div_by_zero_in;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic        busy;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic        pc_load;
    logic [31:0] pc_value;
    logic [31:0] epc_out;
    logic [1:0]  cause_out;

    modport master (
        output check_en, invalid_opcode_in, overflow_in, div_by_zero_in, pc_in, mem_data_in,
        input  busy, mem_sel, mem_addr, pc_load, pc_value, epc_out, cause_out
    );

    modport slave (
        input  check_en, invalid_opcode_in, overflow_in, div_by_zero_in, pc_in, mem_data_in,
        output busy, mem_sel, mem_addr, pc_load, pc_value, epc_out, cause_out
    );

endinterface

// File: rtl/exc_byte_select.sv
// Combinational 32->8 byte lane mux; lane chosen by the low two address bits.
module exc_byte_select (
    input  logic [31:0] word_i,
    input  logic [1:0]  sel_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = word_i[7:0];
        case (sel_i)
            2'b00: byte_o = word_i[7:0];
            2'b01: byte_o = word_i[15:8];
            2'b10: byte_o = word_i[23:16];
            2'b11: byte_o = word_i[31:24];
            default: byte_o = word_i[7:0];
        endcase
    end

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer: latches cause/EPC, reads a vector byte after MEM_WAIT cycles, strobes pc_load.
// Latency request edge -> pc_load is MEM_WAIT+1 cycles; requests while busy are dropped, not queued.
module exception_unit
    import exc_pkg::*;
#(
    parameter int          MEM_WAIT = 2,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    exception_unit_if.slave  eu
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  lane_byte;
    logic [31:0] vec_addr;
    logic        any_req;

    assign any_req  = eu.invalid_opcode_in | eu.overflow_in | eu.div_by_zero_in;
    assign vec_addr = VEC_BASE + {30'd0, cause_q};

    exc_byte_select u_byte_sel (
        .word_i (eu.mem_data_in),
        .sel_i  (vec_addr[1:0]),
        .byte_o (lane_byte)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (eu.check_en && any_req) begin
                    cause_d = pick_cause(eu.invalid_opcode_in, eu.overflow_in, eu.div_by_zero_in);
                    epc_d   = eu.pc_in - 32'd4;
                    cnt_d   = 4'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    byte_d  = lane_byte;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q   <= 4'd0;
            epc_q   <= 32'd0;
            byte_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            byte_q  <= byte_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them within the same cycle.
    assign eu.busy      = (state_q != ST_IDLE);
    assign eu.mem_sel   = (state_q == ST_WAIT);
    assign eu.mem_addr  = eu.mem_sel ? vec_addr : 32'd0;
    assign eu.pc_load   = (state_q == ST_LOAD);
    assign eu.pc_value  = eu.pc_load ? {24'd0, byte_q} : 32'd0;
    assign eu.epc_out   = epc_q;
    assign eu.cause_out = cause_q;

endmodule

// File: tb/tb_exception_unit.sv
// Scenario bench for exception_unit with a queue of expected handler addresses.
module tb_exception_unit;

    localparam int MEM_WAIT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    exception_unit_if eu_if ();

    exception_unit #(.MEM_WAIT(MEM_WAIT), .VEC_BASE(32'd252)) dut (
        .clk   (clk),
        .reset (reset),
        .eu    (eu_if)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          pl_count = 0;
    int          exp_pl = 0;
    int          zero_viol = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_epc = 32'd0;
    logic [1:0]  last_cause = 2'b00;

    always @(negedge clk) begin
        if (eu_if.pc_load === 1'b1) pl_count++;
        else if (eu_if.pc_value !== 32'd0) zero_viol++;
    end

    task automatic clear_inputs();
        eu_if.check_en          = 1'b0;
        eu_if.invalid_opcode_in = 1'b0;
        eu_if.overflow_in       = 1'b0;
        eu_if.div_by_zero_in    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        eu_if.pc_in       = 32'd0;
        eu_if.mem_data_in = 32'h33221100;
        #3;
        total++;
        if ({eu_if.busy, eu_if.mem_sel, eu_if.pc_load, eu_if.cause_out} !== 5'd0 ||
            eu_if.mem_addr !== 32'd0 || eu_if.pc_value !== 32'd0 || eu_if.epc_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b sel=%b load=%b cause=%b addr=%h val=%h epc=%h, want all 0",
                     eu_if.busy, eu_if.mem_sel, eu_if.pc_load, eu_if.cause_out,
                     eu_if.mem_addr, eu_if.pc_value, eu_if.epc_out);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (eu_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b want 0", eu_if.busy);
        end
    endtask

    task automatic run_exc(input string name, input logic inv, input logic ovf, input logic dz,
                           input logic [31:0] pc, input logic [1:0] ecause, input logic [31:0] eepc,
                           input logic [31:0] eaddr, input logic [31:0] evalue);
        int cyc;
        logic [31:0] e;
        @(posedge clk); #1;
        eu_if.check_en = 1'b1;
        eu_if.invalid_opcode_in = inv;
        eu_if.overflow_in = ovf;
        eu_if.div_by_zero_in = dz;
        eu_if.pc_in = pc;
        exp_q.push_back(evalue);
        exp_pl++;
        @(posedge clk); #1;
        clear_inputs();
        total++;
        if (eu_if.busy !== 1'b1 || eu_if.mem_sel !== 1'b1 || eu_if.mem_addr !== eaddr) begin
            bad++;
            $display("FAIL %s_wait: busy=%b sel=%b addr=%h, want 1 1 %h",
                     name, eu_if.busy, eu_if.mem_sel, eu_if.mem_addr, eaddr);
        end
        total++;
        if (eu_if.epc_out !== eepc || eu_if.cause_out !== ecause) begin
            bad++;
            $display("FAIL %s_latch: epc=%h cause=%b, want %h %b",
                     name, eu_if.epc_out, eu_if.cause_out, eepc, ecause);
        end
        cyc = 1;
        while (eu_if.pc_load !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (eu_if.pc_load !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: no pc_load within %0d cycles", name, cyc);
        end else begin
            if (cyc != MEM_WAIT + 1 || eu_if.mem_sel !== 1'b0 || eu_if.busy !== 1'b1) begin
                bad++;
                $display("FAIL %s_latency: pc_load at cycle %0d sel=%b busy=%b, want %0d 0 1",
                         name, cyc, eu_if.mem_sel, eu_if.busy, MEM_WAIT + 1);
            end
            total++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            if (eu_if.pc_value !== e) begin
                bad++;
                $display("FAIL %s_value: pc_value=%h want %h", name, eu_if.pc_value, e);
            end
        end
        @(posedge clk); #1;
        total++;
        if (eu_if.busy !== 1'b0 || eu_if.pc_load !== 1'b0) begin
            bad++;
            $display("FAIL %s_return: busy=%b load=%b want 0 0", name, eu_if.busy, eu_if.pc_load);
        end
        last_epc = eepc;
        last_cause = ecause;
    endtask

    task automatic test_overflow();
        run_exc("overflow", 1'b0, 1'b1, 1'b0, 32'h40, 2'b10, 32'h3C, 32'd254, 32'h22);
    endtask

    task automatic test_disabled();
        int start_pl;
        start_pl = pl_count;
        @(posedge clk); #1;
        eu_if.check_en = 1'b0;
        eu_if.div_by_zero_in = 1'b1;
        eu_if.pc_in = 32'h500;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (eu_if.busy !== 1'b0) begin
                bad++;
                $display("FAIL disabled_busy: cycle %0d busy=%b want 0", i, eu_if.busy);
            end
        end
        clear_inputs();
        total++;
        if (pl_count != start_pl || eu_if.epc_out !== last_epc || eu_if.cause_out !== last_cause) begin
            bad++;
            $display("FAIL disabled_hold: loads=%0d epc=%h cause=%b, want %0d %h %b",
                     pl_count, eu_if.epc_out, eu_if.cause_out, start_pl, last_epc, last_cause);
        end
    endtask

    task automatic test_priority();
        run_exc("priority", 1'b1, 1'b1, 1'b1, 32'h80, 2'b01, 32'h7C, 32'd253, 32'h11);
    endtask

    task automatic test_no_nesting();
        int cyc;
        logic [31:0] e;
        @(posedge clk); #1;
        eu_if.check_en = 1'b1;
        eu_if.div_by_zero_in = 1'b1;
        eu_if.pc_in = 32'h100;
        exp_q.push_back(32'h33);
        exp_pl++;
        @(posedge clk); #1;
        clear_inputs();
        eu_if.check_en = 1'b1;
        eu_if.invalid_opcode_in = 1'b1;
        eu_if.pc_in = 32'h900;
        @(posedge clk); #1;
        clear_inputs();
        total++;
        if (eu_if.cause_out !== 2'b11 || eu_if.epc_out !== 32'hFC) begin
            bad++;
            $display("FAIL nest_hold: cause=%b epc=%h want 11 000000fc", eu_if.cause_out, eu_if.epc_out);
        end
        cyc = 2;
        while (eu_if.pc_load !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (eu_if.pc_load !== 1'b1) begin
            bad++;
            $display("FAIL nest_timeout: no pc_load within %0d cycles", cyc);
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            if (eu_if.pc_value !== e || cyc != MEM_WAIT + 1) begin
                bad++;
                $display("FAIL nest_value: pc_value=%h cyc=%0d want %h %0d", eu_if.pc_value, cyc, e, MEM_WAIT + 1);
            end
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (pl_count != exp_pl || eu_if.cause_out !== 2'b11) begin
            bad++;
            $display("FAIL nest_single: loads=%0d cause=%b want %0d 11", pl_count, eu_if.cause_out, exp_pl);
        end
        last_epc = 32'hFC;
        last_cause = 2'b11;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        eu_if.check_en = 1'b1;
        eu_if.overflow_in = 1'b1;
        eu_if.pc_in = 32'h200;
        @(posedge clk); #1;
        clear_inputs();
        total++;
        if (eu_if.busy !== 1'b1 || eu_if.mem_sel !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_started: busy=%b sel=%b want 1 1", eu_if.busy, eu_if.mem_sel);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({eu_if.busy, eu_if.mem_sel, eu_if.pc_load, eu_if.cause_out} !== 5'd0 ||
            eu_if.mem_addr !== 32'd0 || eu_if.pc_value !== 32'd0 || eu_if.epc_out !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_clear: busy=%b sel=%b load=%b cause=%b addr=%h val=%h epc=%h, want all 0",
                     eu_if.busy, eu_if.mem_sel, eu_if.pc_load, eu_if.cause_out,
                     eu_if.mem_addr, eu_if.pc_value, eu_if.epc_out);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (pl_count != exp_pl || eu_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_noload: loads=%0d busy=%b want %0d 0", pl_count, eu_if.busy, exp_pl);
        end
        run_exc("after_reset", 1'b0, 1'b1, 1'b0, 32'h40, 2'b10, 32'h3C, 32'd254, 32'h22);
    endtask

    task automatic test_pc_wrap();
        run_exc("pc_wrap", 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 32'hFFFFFFFC, 32'd253, 32'h11);
    endtask

    task automatic test_back_to_back();
        eu_if.mem_data_in = 32'hA5C3_7E81;
        run_exc("b2b_div", 1'b0, 1'b0, 1'b1, 32'h1004, 2'b11, 32'h1000, 32'd255, 32'hA5);
        run_exc("b2b_ovf", 1'b0, 1'b1, 1'b1, 32'h2008, 2'b10, 32'h2004, 32'd254, 32'hC3);
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_disabled();
        test_priority();
        test_no_nesting();
        test_reset_mid();
        test_pc_wrap();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pl_count != exp_pl || exp_q.size() != 0) begin
            bad++;
            $display("FAIL load_count: loads=%0d pending=%0d want %0d 0", pl_count, exp_q.size(), exp_pl);
        end
        total++;
        if (zero_viol != 0) begin
            bad++;
            $display("FAIL pc_value_idle: %0d cycles with nonzero pc_value while pc_load low, want 0", zero_viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
